// File: rtl/la_capture_qual.sv
// Logic-analyzer capture qualifier: registers the probe bus and generates cqual/trig for the core.
// Define LA_QUAL_HEARTBEAT_EN to compile in the idle heartbeat that bounds gaps between samples.
module la_capture_qual #(
    parameter int unsigned DW       = 16,
    parameter int unsigned IDLE_MAX = 255
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic [DW-1:0] data_in,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] chg_mask,
    input  logic [DW-1:0] trig_mask,
    input  logic [DW-1:0] trig_value,
    input  logic          arm,
    output logic [DW-1:0] data_out,
    output logic          cqual,
    output logic          trig,
    output logic [1:0]    trig_state
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StArmed = 2'b01,
        StFired = 2'b10
    } trig_st_e;

    trig_st_e      state_q, state_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] prev_q;
    logic          cqual_q, cqual_d;
    logic          trig_q;
    logic          first_q, first_d;

    logic          mode_on;
    logic          chg;
    logic          mchg;
    logic          cause;
    logic          match;
    logic          fire;
    logic          hb;

    assign mode_on = (mode != 2'b00);
    assign chg     = |(data_in ^ prev_q);
    assign mchg    = |((data_in ^ prev_q) & chg_mask);
    assign match   = ((data_in ^ trig_value) & trig_mask) == '0;

    always_comb begin
        cause = 1'b0;
        unique case (mode)
            2'b00:   cause = 1'b0;
            2'b01:   cause = 1'b1;
            2'b10:   cause = chg;
            2'b11:   cause = mchg;
            default: cause = 1'b0;
        endcase
    end

    // Arming from IDLE never fires in the same cycle; fire needs a matching cycle while ARMED.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        case (state_q)
            StIdle: begin
                if (arm) state_d = StArmed;
            end
            StArmed: begin
                if (!arm) begin
                    state_d = StIdle;
                end else if (match) begin
                    state_d = StFired;
                    fire    = 1'b1;
                end
            end
            StFired: begin
                if (!arm) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // The first-sample request survives mode 00 and is consumed by the first qualified cycle.
    assign first_d = first_q & ~mode_on;
    assign cqual_d = mode_on & (cause | first_q | fire | hb);

`ifdef LA_QUAL_HEARTBEAT_EN
    localparam int unsigned CntW = (IDLE_MAX > 1) ? $clog2(IDLE_MAX) : 1;

    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

    assign hb = (idle_cnt_q == CntW'(IDLE_MAX - 1));

    always_comb begin
        idle_cnt_d = idle_cnt_q + CntW'(1);
        if (!mode_on || cqual_d) begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign hb = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= StIdle;
            data_q  <= '0;
            prev_q  <= '0;
            cqual_q <= 1'b0;
            trig_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_in;
            prev_q  <= data_in;
            cqual_q <= cqual_d;
            trig_q  <= fire;
            first_q <= first_d;
        end
    end

    assign data_out   = data_q;
    assign cqual      = cqual_q;
    assign trig       = trig_q;
    assign trig_state = state_q;

endmodule
